serial_frame_tx: RTL and testbench

// - Parallel-to-serial framed transmitter; transmit-side counterpart of our serial-to-parallel receive shift register.
// - Accepts a NUM_BITS word over a valid/ready handshake and emits one framed bit stream on serial_out:

---
 rtl/serial_frame_tx.sv | 172 +++++++++++++++++
 tb/tb_serial_frame_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start 0, data, optional parity, stop 1.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit after the data.
module serial_frame_tx #(
    parameter int NUM_BITS     = 8,
    parameter int SHIFT_MSB    = 1,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_MAX = CW'(NUM_BITS - 1);
    localparam logic [NUM_BITS-1:0] TOP_ONE = NUM_BITS'(1) << (NUM_BITS - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic                serial_out_q, serial_out_d;
    logic                tx_ready_q, tx_ready_d;
    logic                tx_busy_q, tx_busy_d;
    logic                frame_done_q, frame_done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic [NUM_BITS-1:0] shift_nx;
    logic                head_q, head_nx, bit_end;

    always_comb begin
        if (SHIFT_MSB != 0) begin
            shift_nx = (shift_q << 1) | NUM_BITS'(1);
            head_q   = shift_q[NUM_BITS-1];
            head_nx  = shift_nx[NUM_BITS-1];
        end else begin
            shift_nx = (shift_q >> 1) | TOP_ONE;
            head_q   = shift_q[0];
            head_nx  = shift_nx[0];
        end
    end

    assign bit_end = (timer_q == T_MAX);

    always_comb begin
        state_d      = state_q;
        timer_d      = bit_end ? '0 : timer_q + TW'(1);
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        serial_out_d = serial_out_q;
        tx_ready_d   = 1'b0;
        tx_busy_d    = 1'b1;
        frame_done_d = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                timer_d      = '0;
                cnt_d        = '0;
                serial_out_d = 1'b1;
                tx_ready_d   = 1'b1;
                tx_busy_d    = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    shift_d      = tx_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d     = ^tx_data;
`endif
                    state_d      = START;
                    serial_out_d = 1'b0;
                    tx_ready_d   = 1'b0;
                    tx_busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d      = DATA;
                    serial_out_d = head_q;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (cnt_q == C_MAX) begin
                        cnt_d        = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d      = PARITY;
                        serial_out_d = parity_q;
`else
                        state_d      = STOP;
                        serial_out_d = 1'b1;
`endif
                    end else begin
                        cnt_d        = cnt_q + CW'(1);
                        shift_d      = shift_nx;
                        serial_out_d = head_nx;
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d      = STOP;
                    serial_out_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d      = IDLE;
                    serial_out_d = 1'b1;
                    tx_ready_d   = 1'b1;
                    tx_busy_d    = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                serial_out_d = 1'b1;
                tx_ready_d   = 1'b1;
                tx_busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            shift_q      <= '1;
            serial_out_q <= 1'b1;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign serial_out = serial_out_q;
    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: MSB-first, LSB-first and one-clock-per-bit
// instances, with table-driven frames plus reset, back-to-back and abort sequences.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 10 + PB;

    typedef struct {
        logic [7:0] data;
        logic [7:0] lsb_seq;
        logic       par;
    } vec_t;

    logic       clk;
    logic       n_rst;
    logic [7:0] txd [3];
    logic [2:0] tv;
    logic [2:0] rdy, so, bsy, dn;

    int tests;
    int fails;

    serial_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4)) u_msb (
        .clk(clk), .n_rst(n_rst), .tx_data(txd[0]), .tx_valid(tv[0]),
        .tx_ready(rdy[0]), .serial_out(so[0]), .tx_busy(bsy[0]),
        .frame_done(dn[0])
    );

    serial_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4)) u_lsb (
        .clk(clk), .n_rst(n_rst), .tx_data(txd[1]), .tx_valid(tv[1]),
        .tx_ready(rdy[1]), .serial_out(so[1]), .tx_busy(bsy[1]),
        .frame_done(dn[1])
    );

    serial_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(1)) u_c1 (
        .clk(clk), .n_rst(n_rst), .tx_data(txd[2]), .tx_valid(tv[2]),
        .tx_ready(rdy[2]), .serial_out(so[2]), .tx_busy(bsy[2]),
        .frame_done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk($sformatf("%s d%0d serial_out", tag, i), so[i], 1'b1);
        chk($sformatf("%s d%0d tx_ready", tag, i), rdy[i], 1'b1);
        chk($sformatf("%s d%0d tx_busy", tag, i), bsy[i], 1'b0);
        chk($sformatf("%s d%0d frame_done", tag, i), dn[i], 1'b0);
    endtask

    function automatic logic [10:0] mk_line(input logic [7:0] seq, input logic par);
        if (PB != 0) return {1'b0, seq, par, 1'b1};
        else         return {1'b0, 1'b0, seq, 1'b1};
    endfunction

    // Next negedge is cycle 1 after the accepting edge for every enabled DUT.
    task automatic watch(input logic [2:0] en, input logic [10:0] l0,
                         input logic [10:0] l1, input logic [10:0] l2);
        logic [10:0] ln [3];
        int cpb [3];
        int len [3];
        int kmax;
        int idx;
        ln[0] = l0; ln[1] = l1; ln[2] = l2;
        cpb[0] = 4; cpb[1] = 4; cpb[2] = 1;
        kmax = 0;
        for (int i = 0; i < 3; i++) begin
            len[i] = FB * cpb[i];
            if (en[i] && len[i] + 1 > kmax) kmax = len[i] + 1;
        end
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (en[i] && k <= len[i]) begin
                    idx = (k - 1) / cpb[i];
                    chk($sformatf("d%0d k%0d serial_out", i, k), so[i], ln[i][FB-1-idx]);
                    chk($sformatf("d%0d k%0d tx_busy", i, k), bsy[i], 1'b1);
                    chk($sformatf("d%0d k%0d tx_ready", i, k), rdy[i], 1'b0);
                    chk($sformatf("d%0d k%0d frame_done", i, k), dn[i], 1'b0);
                end else if (en[i] && k == len[i] + 1) begin
                    chk($sformatf("d%0d end serial_out", i), so[i], 1'b1);
                    chk($sformatf("d%0d end tx_busy", i), bsy[i], 1'b0);
                    chk($sformatf("d%0d end tx_ready", i), rdy[i], 1'b1);
                    chk($sformatf("d%0d end frame_done", i), dn[i], 1'b1);
                end
            end
        end
    endtask

    initial begin
        vec_t vt [6];
        logic [10:0] lm, ll;
        tests = 0;
        fails = 0;

        vt[0] = '{data: 8'hA5, lsb_seq: 8'hA5, par: 1'b0};
        vt[1] = '{data: 8'h01, lsb_seq: 8'h80, par: 1'b1};
        vt[2] = '{data: 8'h37, lsb_seq: 8'hEC, par: 1'b1};
        vt[3] = '{data: 8'h07, lsb_seq: 8'hE0, par: 1'b1};
        vt[4] = '{data: 8'hFF, lsb_seq: 8'hFF, par: 1'b0};
        vt[5] = '{data: 8'h5A, lsb_seq: 8'h5A, par: 1'b0};

        // Reset held two edges with tx_valid high: no accept.
        n_rst = 1'b0;
        tv = 3'b111;
        for (int i = 0; i < 3; i++) txd[i] = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        end
        tv = 3'b000;
        n_rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, "post_reset");

        // Table-driven frames on all three instances.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            tv = 3'b111;
            for (int i = 0; i < 3; i++) txd[i] = vt[v].data;
            @(posedge clk); #1;
            tv = 3'b000;
            for (int i = 0; i < 3; i++) txd[i] = ~vt[v].data;
            lm = mk_line(vt[v].data, vt[v].par);
            ll = mk_line(vt[v].lsb_seq, vt[v].par);
            watch(3'b111, lm, ll, lm);
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk_idle(i, $sformatf("v%0d after", v));
        end

        // Back-to-back: 8'h00 then 8'hFF with tx_valid held throughout.
        @(posedge clk); #1;
        tv[0] = 1'b1;
        txd[0] = 8'h00;
        @(posedge clk); #1;
        txd[0] = 8'hFF;
        watch(3'b001, mk_line(8'h00, 1'b0), 11'h0, 11'h0);
        @(posedge clk); #1;
        tv[0] = 1'b0;
        txd[0] = 8'h3C;
        // Cycle 1 of this watch is the second start bit, one cycle after frame_done.
        watch(3'b001, mk_line(8'hFF, 1'b0), 11'h0, 11'h0);
        @(negedge clk);
        chk_idle(0, "b2b after");

        // Reset at cycle 15 of a frame aborts it.
        @(posedge clk); #1;
        tv[0] = 1'b1;
        txd[0] = 8'h00;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("abort pre serial_out", so[0], 1'b0);
        chk("abort pre tx_busy", bsy[0], 1'b1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle(0, "abort");
        repeat (3) @(negedge clk);
        chk_idle(0, "abort hold");

        // Full new frame after the aborted one.
        @(posedge clk); #1;
        tv[0] = 1'b1;
        txd[0] = 8'hC6;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        watch(3'b001, mk_line(8'hC6, 1'b0), 11'h0, 11'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
